// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: forwarding selects, load-use stall, redirect flush, memory freeze
// Shadow stage entries track EX and MEM destinations so ID can pick bypass paths without reaching into the datapath.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_stall,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_freeze,
  output logic [1:0]  forward_op1,
  output logic [1:0]  forward_op2,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, BUBBLE, FREEZE} state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  state_t      state_q, state_d;
  state_t      saved_q, saved_d;
  state_t      eff_state;
  logic [4:0]  ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic        ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d;
  logic        ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d;
  logic [1:0]  fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [15:0] cnt_q, cnt_d;

  logic        rs1_rel, rs2_rel;
  logic        rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
  logic [1:0]  sel1, sel2;
  logic        load_use;

  assign rs1_rel = id_valid && id_rs1_used && (id_rs1 != 5'd0);
  assign rs2_rel = id_valid && id_rs2_used && (id_rs2 != 5'd0);

  assign rs1_ex_hit  = rs1_rel && ex_wr_q  && (ex_rd_q  == id_rs1);
  assign rs2_ex_hit  = rs2_rel && ex_wr_q  && (ex_rd_q  == id_rs2);
  assign rs1_mem_hit = rs1_rel && mem_wr_q && (mem_rd_q == id_rs1);
  assign rs2_mem_hit = rs2_rel && mem_wr_q && (mem_rd_q == id_rs2);

  // A load in EX cannot be bypassed from EX; it is served from WB after one bubble.
  assign sel1 = (rs1_ex_hit && !ex_ld_q) ? FWD_MEM : (rs1_mem_hit ? FWD_WB : FWD_NONE);
  assign sel2 = (rs2_ex_hit && !ex_ld_q) ? FWD_MEM : (rs2_mem_hit ? FWD_WB : FWD_NONE);

  // Leaving FREEZE resumes whatever state was interrupted in the same cycle.
  assign eff_state = (state_q == FREEZE) ? saved_q : state_q;
  assign load_use  = ex_ld_q && (rs1_ex_hit || rs2_ex_hit) && (eff_state == RUN);

  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    state_d      = state_q;
    saved_d      = saved_q;
    ex_rd_d      = ex_rd_q;
    ex_wr_d      = ex_wr_q;
    ex_ld_d      = ex_ld_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_ld_d     = mem_ld_q;
    fwd1_d       = fwd1_q;
    fwd2_d       = fwd2_q;
    if (rst) begin
      state_d = RUN;
      saved_d = RUN;
    end else if (mem_stall) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      pipe_freeze = 1'b1;
      state_d     = FREEZE;
      if (state_q != FREEZE) saved_d = state_q;
    end else begin
      mem_rd_d = ex_rd_q;
      mem_wr_d = ex_wr_q;
      mem_ld_d = ex_ld_q;
      if (ex_redirect || load_use) begin
        ex_rd_d      = 5'd0;
        ex_wr_d      = 1'b0;
        ex_ld_d      = 1'b0;
        fwd1_d       = FWD_NONE;
        fwd2_d       = FWD_NONE;
        id_ex_bubble = 1'b1;
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          state_d     = RUN;
        end else begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          state_d    = BUBBLE;
        end
      end else begin
        ex_rd_d = id_valid ? id_rd        : 5'd0;
        ex_wr_d = id_valid && id_reg_write;
        ex_ld_d = id_valid && id_mem_read;
        fwd1_d  = sel1;
        fwd2_d  = sel2;
        state_d = RUN;
      end
    end
  end

  assign cnt_d = (pc_hold && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      saved_q  <= RUN;
      ex_rd_q  <= 5'd0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      mem_wr_q <= 1'b0;
      mem_ld_q <= 1'b0;
      fwd1_q   <= FWD_NONE;
      fwd2_q   <= FWD_NONE;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      ex_rd_q  <= ex_rd_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      mem_ld_q <= mem_ld_d;
      fwd1_q   <= fwd1_d;
      fwd2_q   <= fwd2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign forward_op1 = fwd1_q;
  assign forward_op2 = fwd2_q;
  assign stall_cnt   = cnt_q;

  // mem_ld_q is kept for a complete shadow entry; nothing downstream needs it yet.
  logic unused_mem_ld;
  assign unused_mem_ld = mem_ld_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk, rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, mem_stall;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0]  forward_op1, forward_op2;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .forward_op1(forward_op1), .forward_op2(forward_op2), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idv(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic wr, input logic ld);
    id_valid     = 1'b1;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
    #1;
  endtask

  task automatic ctl(input string tag, input logic [4:0] exp);
    check({tag, "_ctl"}, {11'd0, pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze}, {11'd0, exp});
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; mem_stall = 1'b1;
    idv(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    ctl("rst_comb", 5'b00000);
    tick(); tick();
    check("rst_fwd1", {14'd0, forward_op1}, 16'd0);
    check("rst_fwd2", {14'd0, forward_op2}, 16'd0);
    check("rst_cnt", stall_cnt, 16'd0);
    rst = 1'b0; mem_stall = 1'b0;

    // EX and MEM forwarding
    idv(0, 0, 0, 0, 5, 1, 0); tick();
    idv(5, 1, 0, 0, 7, 1, 0); ctl("fwd_ex", 5'b00000); tick();
    check("fwd_ex_op1", {14'd0, forward_op1}, 16'd1);
    idv(5, 1, 7, 1, 0, 0, 0); tick();
    check("fwd_mem_op1", {14'd0, forward_op1}, 16'd2);
    check("fwd_ex_op2", {14'd0, forward_op2}, 16'd1);

    // load-use on rs2
    idv(0, 0, 0, 0, 6, 1, 1); tick();
    idv(0, 0, 6, 1, 8, 1, 0); ctl("lu_stall", 5'b11010); tick();
    check("lu_bub_op2", {14'd0, forward_op2}, 16'd0);
    check("lu_cnt", stall_cnt, 16'd1);
    ctl("lu_bubble_state", 5'b00000); tick();
    check("lu_wb_op2", {14'd0, forward_op2}, 16'd2);

    // x0 and unused sources never hazard
    idv(0, 0, 0, 0, 0, 1, 1); tick();
    idv(0, 1, 0, 1, 9, 1, 1); ctl("x0", 5'b00000); tick();
    check("x0_op1", {14'd0, forward_op1}, 16'd0);
    idv(9, 0, 9, 0, 0, 0, 0); ctl("unused", 5'b00000); tick();
    check("unused_ops", {12'd0, forward_op1, forward_op2}, 16'd0);

    // redirect beats load-use
    idv(0, 0, 0, 0, 10, 1, 1); tick();
    idv(10, 1, 0, 0, 0, 0, 0); ex_redirect = 1'b1; #1;
    ctl("redir", 5'b00110); tick();
    ex_redirect = 1'b0;
    check("redir_op1", {14'd0, forward_op1}, 16'd0);
    check("redir_cnt", stall_cnt, 16'd1);
    #1; ctl("redir_after", 5'b00000); tick();
    check("redir_wb_op1", {14'd0, forward_op1}, 16'd2);

    // freeze during BUBBLE
    idv(0, 0, 0, 0, 11, 1, 1); tick();
    idv(11, 1, 0, 0, 12, 1, 0); ctl("fz_lu", 5'b11010); tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; ctl("fz_bub", 5'b11001); tick();
      check("fz_bub_op1", {14'd0, forward_op1}, 16'd0);
    end
    check("fz_cnt", stall_cnt, 16'd5);
    mem_stall = 1'b0; #1;
    ctl("fz_release", 5'b00000); tick();
    check("fz_done_op1", {14'd0, forward_op1}, 16'd2);

    // freeze holds a nonzero select
    idv(12, 1, 0, 0, 0, 0, 0); tick();
    check("hold_pre", {14'd0, forward_op1}, 16'd1);
    mem_stall = 1'b1; idv(0, 0, 0, 0, 0, 0, 0); tick();
    check("hold_op1", {14'd0, forward_op1}, 16'd1);
    mem_stall = 1'b0; #1; tick();
    check("hold_rel_op1", {14'd0, forward_op1}, 16'd0);
    check("hold_cnt", stall_cnt, 16'd6);

    // reset during FREEZE leaves no residue
    idv(0, 0, 0, 0, 13, 1, 0); tick();
    idv(13, 1, 0, 0, 0, 0, 0); tick();
    mem_stall = 1'b1; tick();
    rst = 1'b1; #1;
    ctl("rst_fz_comb", 5'b00000); tick();
    rst = 1'b0; mem_stall = 1'b0; #1;
    ctl("rst_fz_after", 5'b00000);
    check("rst_fz_cnt", stall_cnt, 16'd0);
    check("rst_fz_op1", {14'd0, forward_op1}, 16'd0);
    tick();
    check("rst_fz_shadow", {14'd0, forward_op1}, 16'd0);

    // saturation
    id_valid = 1'b0; mem_stall = 1'b1;
    repeat (65534) tick();
    check("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    check("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (5) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    mem_stall = 1'b0; #1; tick();
    check("sat_after", stall_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
